// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the parametrised register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_DONE  = 2'b10
  } clr_state_e;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: one write port, two read ports and clear handshake.
interface regfile_if #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_pkg::DEF_ADDR_W
);

  logic              load;
  logic [ADDR_W-1:0] ds;
  logic [DATA_W-1:0] ddata;
  logic [ADDR_W-1:0] sa;
  logic [ADDR_W-1:0] sb;
  logic [DATA_W-1:0] adata;
  logic [DATA_W-1:0] bdata;
  logic              avalid;
  logic              bvalid;
  logic              clr_req;
  logic              busy;
  logic              clr_done;
  logic              wr_rej;

  modport master (
    output load, ds, ddata, sa, sb, clr_req,
    input  adata, bdata, avalid, bvalid, busy, clr_done, wr_rej
  );

  modport slave (
    input  load, ds, ddata, sa, sb, clr_req,
    output adata, bdata, avalid, bvalid, busy, clr_done, wr_rej
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every entry once, one per cycle, then pulses done.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

  clr_state_e        state_q;
  clr_state_e        state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;

  // Next-state, counter and clear-strobe decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_en_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_en_o = 1'b1;
        // Wraps naturally in ADDR_W bits after the last entry.
        cnt_d    = cnt_q + ADDR_ONE;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, counter and handshake flops; reset abandons any clear in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign clr_done_o = done_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with valid tracking and clear engine.
// Define REGFILE_BYPASS_EN to forward an accepted write to matching read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic     clk,
  input logic     rst,
  regfile_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic              busy_s;
  logic              clr_en_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              wr_en_s;
  logic              byp_a_s;
  logic              byp_b_s;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_req_i  (bus.clr_req),
    .busy_o     (busy_s),
    .clr_done_o (bus.clr_done),
    .clr_en_o   (clr_en_s),
    .clr_addr_o (clr_addr_s)
  );

  assign wr_en_s    = bus.load & ~busy_s;
  assign bus.busy   = busy_s;
  assign bus.wr_rej = bus.load & busy_s;

`ifdef REGFILE_BYPASS_EN
  assign byp_a_s = wr_en_s & (bus.ds == bus.sa);
  assign byp_b_s = wr_en_s & (bus.ds == bus.sb);
`else
  assign byp_a_s = 1'b0;
  assign byp_b_s = 1'b0;
`endif

  // Storage and valid bits; the clear engine and user writes never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      valid_q <= {DEPTH{1'b0}};
    end else if (clr_en_s) begin
      mem_q[clr_addr_s]   <= {DATA_W{1'b0}};
      valid_q[clr_addr_s] <= 1'b0;
    end else if (wr_en_s) begin
      mem_q[bus.ds]   <= bus.ddata;
      valid_q[bus.ds] <= 1'b1;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    if (byp_a_s) begin
      bus.adata  = bus.ddata;
      bus.avalid = 1'b1;
    end else begin
      bus.adata  = mem_q[bus.sa];
      bus.avalid = valid_q[bus.sa];
    end
    if (byp_b_s) begin
      bus.bdata  = bus.ddata;
      bus.bvalid = 1'b1;
    end else begin
      bus.bdata  = mem_q[bus.sb];
      bus.bvalid = valid_q[bus.sb];
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios on an 8x8 instance
// plus a randomized run checked on both 8x8 and 16x16 instances.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  regfile_if #(.DATA_W(8),  .ADDR_W(3)) n_if ();
  regfile_if #(.DATA_W(16), .ADDR_W(4)) w_if ();

  regfile_param #(.DATA_W(8),  .ADDR_W(3)) dut_n (.clk(clk), .rst(rst), .bus(n_if));
  regfile_param #(.DATA_W(16), .ADDR_W(4)) dut_w (.clk(clk), .rst(rst), .bus(w_if));

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;
  bit bypass_on;

  logic [15:0] m_mem [2][16];
  bit          m_val [2][16];
  int          m_n   [2];
  bit          m_act [2];

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic idle_inputs();
    n_if.load = 1'b0; n_if.ds = 3'd0; n_if.ddata = 8'h00;
    n_if.sa = 3'd0; n_if.sb = 3'd0; n_if.clr_req = 1'b0;
    w_if.load = 1'b0; w_if.ds = 4'd0; w_if.ddata = 16'h0000;
    w_if.sa = 4'd0; w_if.sb = 4'd0; w_if.clr_req = 1'b0;
  endtask

  task automatic fill_all(input logic [7:0] v);
    n_if.load = 1'b1;
    n_if.ddata = v;
    for (int i = 0; i < 8; i++) begin
      n_if.ds = 3'(i);
      tick();
    end
    n_if.load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    n_if.load = 1'b1; n_if.ds = 3'd3; n_if.ddata = 8'hAA;
    tick();
    tick();
    rst = 1'b0;
    n_if.load = 1'b0;
    n_if.sa = 3'd3;
    w_if.sa = 4'd3;
    #1;
    n_tests++;
    if (n_if.adata !== 8'h00 || n_if.avalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read got %h/%b want 00/0", n_if.adata, n_if.avalid);
    end
    n_tests++;
    if (n_if.busy !== 1'b0 || n_if.clr_done !== 1'b0 || w_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags busy=%b done=%b wbusy=%b want 0", n_if.busy, n_if.clr_done, w_if.busy);
    end
    n_tests++;
    if (w_if.adata !== 16'h0000 || w_if.avalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wide got %h/%b want 0000/0", w_if.adata, w_if.avalid);
    end
  endtask

  task automatic test_write_read();
    n_if.sa = 3'd2;
    #1;
    n_tests++;
    if (n_if.avalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_prevalid got %b want 0", n_if.avalid);
    end
    n_if.load = 1'b1; n_if.ds = 3'd2; n_if.ddata = 8'h5A;
    tick();
    n_if.ds = 3'd7; n_if.ddata = 8'hC3;
    tick();
    n_if.load = 1'b0;
    n_if.sa = 3'd2; n_if.sb = 3'd7;
    #1;
    n_tests++;
    if (n_if.adata !== 8'h5A || n_if.bdata !== 8'hC3 || n_if.avalid !== 1'b1 || n_if.bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_read got a=%h b=%h av=%b bv=%b want 5a c3 1 1",
               n_if.adata, n_if.bdata, n_if.avalid, n_if.bvalid);
    end
    n_if.sa = 3'd7;
    #1;
    n_tests++;
    if (n_if.adata !== 8'hC3 || n_if.bdata !== 8'hC3) begin
      n_fail++;
      $display("FAIL wr_same_sel got a=%h b=%h want c3 c3", n_if.adata, n_if.bdata);
    end
  endtask

  task automatic test_clear();
    int done_cnt;
    int done_at;
    fill_all(8'hFF);
    n_if.clr_req = 1'b1;
    tick();
    n_if.clr_req = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    for (int j = 0; j < 11; j++) begin
      n_tests++;
      if (n_if.busy !== (j <= 8)) begin
        n_fail++;
        $display("FAIL clr_busy j=%0d got %b want %b", j, n_if.busy, (j <= 8));
      end
      if (n_if.clr_done === 1'b1) begin
        done_cnt++;
        done_at = j;
      end
      if (j == 4) begin
        for (int e = 0; e < 8; e++) begin
          n_if.sa = 3'(e);
          #1;
          n_tests++;
          if (n_if.adata !== ((e < 4) ? 8'h00 : 8'hFF)) begin
            n_fail++;
            $display("FAIL clr_mid r%0d got %h want %h", e, n_if.adata, ((e < 4) ? 8'h00 : 8'hFF));
          end
        end
      end
      tick();
    end
    n_tests++;
    if (done_cnt != 1 || done_at != 8) begin
      n_fail++;
      $display("FAIL clr_done_pulse got count=%0d at=%0d want 1 at 8", done_cnt, done_at);
    end
    for (int e = 0; e < 8; e++) begin
      n_if.sa = 3'(e);
      #1;
      n_tests++;
      if (n_if.adata !== 8'h00 || n_if.avalid !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_after r%0d got %h/%b want 00/0", e, n_if.adata, n_if.avalid);
      end
    end
  endtask

  task automatic test_write_during_clear();
    int busy_cnt;
    n_if.load = 1'b1; n_if.ds = 3'd5; n_if.ddata = 8'h77;
    tick();
    n_if.ds = 3'd6; n_if.ddata = 8'h42; n_if.clr_req = 1'b1;
    #1;
    n_tests++;
    if (n_if.wr_rej !== 1'b0) begin
      n_fail++;
      $display("FAIL wdc_idle_rej got %b want 0", n_if.wr_rej);
    end
    tick();
    n_if.load = 1'b0; n_if.clr_req = 1'b0;
    busy_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      if (n_if.busy !== 1'b1) break;
      busy_cnt++;
      if (j == 0) begin
        n_if.sa = 3'd6;
        #1;
        n_tests++;
        if (n_if.adata !== 8'h42 || n_if.avalid !== 1'b1) begin
          n_fail++;
          $display("FAIL wdc_same_cycle_write got %h/%b want 42/1", n_if.adata, n_if.avalid);
        end
      end
      if (j == 2) begin
        n_if.load = 1'b1; n_if.ds = 3'd5; n_if.ddata = 8'h11;
        #1;
        n_tests++;
        if (n_if.wr_rej !== 1'b1) begin
          n_fail++;
          $display("FAIL wdc_rej got %b want 1", n_if.wr_rej);
        end
      end
      if (j == 3) begin
        n_if.load = 1'b0;
        n_if.clr_req = 1'b1;
      end
      if (j == 4) n_if.clr_req = 1'b0;
      tick();
    end
    n_if.load = 1'b0; n_if.clr_req = 1'b0;
    n_tests++;
    if (busy_cnt != 9) begin
      n_fail++;
      $display("FAIL wdc_busy_len got %0d want 9", busy_cnt);
    end
    n_if.sa = 3'd5; n_if.sb = 3'd6;
    #1;
    n_tests++;
    if (n_if.adata !== 8'h00 || n_if.avalid !== 1'b0 || n_if.bdata !== 8'h00 || n_if.bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wdc_after got r5=%h/%b r6=%h/%b want 00/0 00/0",
               n_if.adata, n_if.avalid, n_if.bdata, n_if.bvalid);
    end
  endtask

  task automatic test_reset_mid_clear();
    fill_all(8'hFF);
    n_if.clr_req = 1'b1;
    tick();
    n_if.clr_req = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (n_if.busy !== 1'b0 || n_if.clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmc_flags busy=%b done=%b want 0 0", n_if.busy, n_if.clr_done);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_tests++;
      if (n_if.busy !== 1'b0 || n_if.clr_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rmc_quiet k=%0d busy=%b done=%b want 0 0", k, n_if.busy, n_if.clr_done);
      end
    end
    for (int e = 0; e < 8; e++) begin
      n_if.sa = 3'(e);
      #1;
      n_tests++;
      if (n_if.adata !== 8'h00 || n_if.avalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rmc_entry r%0d got %h/%b want 00/0", e, n_if.adata, n_if.avalid);
      end
    end
  endtask

  task automatic test_bypass();
    n_if.load = 1'b1; n_if.ds = 3'd4; n_if.ddata = 8'h3C;
    n_if.sa = 3'd4; n_if.sb = 3'd4;
    #1;
    n_tests++;
    if (n_if.adata !== (bypass_on ? 8'h3C : 8'h00) || n_if.avalid !== bypass_on
        || n_if.bdata !== (bypass_on ? 8'h3C : 8'h00)) begin
      n_fail++;
      $display("FAIL bypass_same got a=%h av=%b b=%h want bypass=%b",
               n_if.adata, n_if.avalid, n_if.bdata, bypass_on);
    end
    tick();
    n_if.load = 1'b0;
    #1;
    n_tests++;
    if (n_if.adata !== 8'h3C || n_if.avalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_next got %h/%b want 3c/1", n_if.adata, n_if.avalid);
    end
  endtask

  task automatic test_random();
    logic [3:0]  r_ds, r_sa, r_sb;
    logic [15:0] r_dd;
    bit          r_load, r_clr;
    logic [36:0] got, exp;
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_act[c] = 1'b0;
      m_n[c]   = 0;
      for (int i = 0; i < 16; i++) begin
        m_mem[c][i] = 16'h0000;
        m_val[c][i] = 1'b0;
      end
    end
    for (int it = 0; it < 600; it++) begin
      r_load = 1'($urandom_range(0, 1));
      r_clr  = ($urandom_range(0, 29) == 0);
      r_ds   = 4'($urandom_range(0, 15));
      r_sa   = 4'($urandom_range(0, 15));
      r_sb   = 4'($urandom_range(0, 15));
      r_dd   = 16'($urandom);
      if (it % 7 == 0) r_sa = r_ds;
      n_if.load = r_load; n_if.ds = r_ds[2:0]; n_if.ddata = r_dd[7:0];
      n_if.sa = r_sa[2:0]; n_if.sb = r_sb[2:0]; n_if.clr_req = r_clr;
      w_if.load = r_load; w_if.ds = r_ds; w_if.ddata = r_dd;
      w_if.sa = r_sa; w_if.sb = r_sb; w_if.clr_req = r_clr;
      #1;
      for (int c = 0; c < 2; c++) begin
        int d, am, ia, ib, iw;
        logic [15:0] dm, ea, eb;
        bit eav, ebv, bsy, dn;
        d  = (c == 0) ? 8 : 16;
        am = d - 1;
        dm = (c == 0) ? 16'h00FF : 16'hFFFF;
        ia = int'(r_sa) & am;
        ib = int'(r_sb) & am;
        iw = int'(r_ds) & am;
        bsy = m_act[c] && (ecount >= m_n[c]) && (ecount <= m_n[c] + d);
        dn  = m_act[c] && (ecount == m_n[c] + d);
        ea = m_mem[c][ia]; eav = m_val[c][ia];
        eb = m_mem[c][ib]; ebv = m_val[c][ib];
        if (bypass_on && r_load && !bsy && iw == ia) begin ea = r_dd & dm; eav = 1'b1; end
        if (bypass_on && r_load && !bsy && iw == ib) begin eb = r_dd & dm; ebv = 1'b1; end
        exp = {ea, eb, eav, ebv, bsy, dn, (r_load && bsy)};
        if (c == 0)
          got = {8'h00, n_if.adata, 8'h00, n_if.bdata, n_if.avalid, n_if.bvalid,
                 n_if.busy, n_if.clr_done, n_if.wr_rej};
        else
          got = {w_if.adata, w_if.bdata, w_if.avalid, w_if.bvalid,
                 w_if.busy, w_if.clr_done, w_if.wr_rej};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random cfg=%0d it=%0d got %h want %h", c, it, got, exp);
        end
        // Entry k of the clear is zeroed at the (k+1)-th edge after the request.
        if (m_act[c] && ecount >= m_n[c] && ecount < m_n[c] + d) begin
          m_mem[c][ecount - m_n[c]] = 16'h0000;
          m_val[c][ecount - m_n[c]] = 1'b0;
        end
        if (r_load && !bsy) begin
          m_mem[c][iw] = r_dd & dm;
          m_val[c][iw] = 1'b1;
        end
        if (r_clr && !bsy) begin
          m_act[c] = 1'b1;
          m_n[c]   = ecount + 1;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
`ifdef REGFILE_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_clear();
    test_write_during_clear();
    test_reset_mid_clear();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
